dmem_arbiter: RTL

- Shares the PCPU's single data-memory port between the CPU and a host/debug requester.
- A host request freezes the CPU through its enable input, then performs one or more host reads/writes, then returns the port to the CPU.
- Burst length is capped and a guaranteed CPU gap follows each burst, so the CPU cannot be starved.
- Sits between PCPU (d_addr/d_dataout/d_we/d_datain/enable) and the data RAM.

---
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_arbiter : shares the PCPU data-memory port with a host/debug requester |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4,
  parameter int MIN_GAP   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_enable_in,
  output logic              cpu_enable,
  input  logic [ADDR_W-1:0] cpu_d_addr,
  input  logic [DATA_W-1:0] cpu_d_dataout,
  input  logic              cpu_d_we,
  output logic [DATA_W-1:0] cpu_d_datain,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int c_BURST_W = $clog2(MAX_BURST + 1);
  localparam int c_GAP_W   = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [c_BURST_W-1:0] c_BURST_LAST = c_BURST_W'(MAX_BURST - 1);
  localparam logic [c_GAP_W-1:0]   c_GAP_LOAD   = c_GAP_W'(MIN_GAP);

  typedef enum logic [1:0] {
    ST_CPU    = 2'd0,
    ST_H_ACC  = 2'd1,
    ST_H_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [c_BURST_W-1:0]  r_burst_cnt;
  logic [c_BURST_W-1:0]  w_burst_nxt;
  logic [c_GAP_W-1:0]    r_gap_cnt;
  logic [c_GAP_W-1:0]    w_gap_nxt;
  logic                  r_ack;
  logic [DATA_W-1:0]     r_rdata;
  logic [ADDR_W-1:0]     w_mem_addr;
  logic [DATA_W-1:0]     w_mem_wdata;
  logic                  w_mem_we;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_CPU;
      r_burst_cnt <= '0;
      r_gap_cnt   <= '0;
      r_ack       <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_next_state;
      r_burst_cnt <= w_burst_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_ack       <= (r_state == ST_H_ACC);
      // Synchronous RAM: data for the H_ACC address is on mem_rdata during H_RESP
      if ((r_state == ST_H_RESP) && !host_we) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_burst_nxt  = r_burst_cnt;
    w_gap_nxt    = r_gap_cnt;
    w_mem_addr   = cpu_d_addr;
    w_mem_wdata  = cpu_d_dataout;
    w_mem_we     = cpu_d_we;
    case (r_state)
      ST_CPU: begin
        if (r_gap_cnt != '0) begin
          w_gap_nxt = r_gap_cnt - c_GAP_W'(1);
        end
        if (host_req && (r_gap_cnt == '0)) begin
          w_next_state = ST_H_ACC;
          w_burst_nxt  = '0;
        end
      end
      ST_H_ACC: begin
        w_mem_addr   = host_addr;
        w_mem_wdata  = host_wdata;
        w_mem_we     = host_we;
        w_next_state = ST_H_RESP;
      end
      ST_H_RESP: begin
        w_mem_addr  = host_addr;
        w_mem_wdata = host_wdata;
        w_mem_we    = 1'b0;
        w_burst_nxt = r_burst_cnt + c_BURST_W'(1);
        // A request still high in the ack cycle is the next transfer of the burst
        if (host_req && (r_burst_cnt < c_BURST_LAST)) begin
          w_next_state = ST_H_ACC;
        end else begin
          w_next_state = ST_CPU;
          w_gap_nxt    = c_GAP_LOAD;
        end
      end
      default: begin
        w_next_state = ST_CPU;
      end
    endcase
  end

  assign cpu_enable   = cpu_enable_in & (r_state == ST_CPU);
  assign host_grant   = (r_state != ST_CPU);
  assign cpu_d_datain = mem_rdata;
  assign host_ack     = r_ack;
  assign host_rdata   = r_rdata;
  assign mem_addr     = w_mem_addr;
  assign mem_wdata    = w_mem_wdata;
  assign mem_we       = w_mem_we;

endmodule
`default_nettype wire
